// File: rtl/celda_serial_tx_if.sv
// Handshake bundle for celda_serial_tx: word input, serial L stream and status.
// master = transmitter side, slave = environment (word source / cell chain).
interface celda_serial_tx_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         L_out;
  logic         L_valid;
  logic         L_ready;
  logic         L_first;
  logic         L_last;
  logic         busy;

  modport master (
    input  in_data, in_valid, L_ready,
    output in_ready, L_out, L_valid, L_first, L_last, busy
  );

  modport slave (
    output in_data, in_valid, L_ready,
    input  in_ready, L_out, L_valid, L_first, L_last, busy
  );
endinterface

// File: rtl/celda_serial_tx.sv
// Serializing transmitter feeding the L stream of the cell-array checker.
// Optional even-parity trailer bit enabled by defining CELDA_PARITY_EN.
module celda_serial_tx #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  celda_serial_tx_if.master bus
);

  localparam int unsigned  CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef CELDA_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          head;
`ifdef CELDA_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    head    = MSB_FIRST ? sr_q[N-1] : sr_q[0];
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef CELDA_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_data;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef CELDA_PARITY_EN
          par_d   = ^bus.in_data;
`endif
        end
      end
      SHIFT: begin
        if (bus.L_ready) begin
          sr_d = MSB_FIRST ? {sr_q[N-2:0], 1'b0} : {1'b0, sr_q[N-1:1]};
          // Counter is cleared on the final transfer instead of wrapping past N-1.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
`ifdef CELDA_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef CELDA_PARITY_EN
      PAR: begin
        if (bus.L_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == IDLE);
    bus.busy     = (state_q != IDLE);
    bus.L_valid  = (state_q != IDLE);
    bus.L_first  = (state_q == SHIFT) && (cnt_q == '0);
    bus.L_out    = 1'b0;
    bus.L_last   = 1'b0;
    if (state_q == SHIFT) bus.L_out = head;
`ifdef CELDA_PARITY_EN
    if (state_q == PAR) begin
      bus.L_out  = par_q;
      bus.L_last = 1'b1;
    end
`else
    bus.L_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef CELDA_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef CELDA_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_celda_serial_tx.sv
// Bench for celda_serial_tx: MSB-first and LSB-first instances driven in lockstep,
// each compared against a frame model derived from the word and bit index.
module tb_celda_serial_tx;
  localparam int unsigned N = 8;
`ifdef CELDA_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         L_ready;
  int           checks = 0;
  int           errors = 0;

  celda_serial_tx_if #(.N(N)) ifa ();
  celda_serial_tx_if #(.N(N)) ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifa.L_ready  = L_ready;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;
  assign ifb.L_ready  = L_ready;

  celda_serial_tx #(.N(N), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  celda_serial_tx #(.N(N), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  always #5 clk = ~clk;

  // Bit k of the frame for word w; index N is the even-parity trailer.
  function automatic logic model_bit(input logic [N-1:0] w, input bit msb, input int k);
    if (k == N) return ^w;
    return msb ? w[N-1-k] : w[k];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string ctx);
    chk({ctx, " A.L_valid"},  ifa.L_valid,  1'b0);
    chk({ctx, " A.L_out"},    ifa.L_out,    1'b0);
    chk({ctx, " A.L_first"},  ifa.L_first,  1'b0);
    chk({ctx, " A.L_last"},   ifa.L_last,   1'b0);
    chk({ctx, " A.busy"},     ifa.busy,     1'b0);
    chk({ctx, " A.in_ready"}, ifa.in_ready, 1'b1);
    chk({ctx, " B.L_valid"},  ifb.L_valid,  1'b0);
    chk({ctx, " B.L_out"},    ifb.L_out,    1'b0);
    chk({ctx, " B.L_first"},  ifb.L_first,  1'b0);
    chk({ctx, " B.L_last"},   ifb.L_last,   1'b0);
    chk({ctx, " B.busy"},     ifb.busy,     1'b0);
    chk({ctx, " B.in_ready"}, ifb.in_ready, 1'b1);
  endtask

  task automatic check_bit(input logic [N-1:0] w, input int k);
    string t;
    t = $sformatf("w=%02h k=%0d", w, k);
    chk({t, " A.L_out"},    ifa.L_out,    model_bit(w, 1'b1, k));
    chk({t, " A.L_valid"},  ifa.L_valid,  1'b1);
    chk({t, " A.L_first"},  ifa.L_first,  k == 0);
    chk({t, " A.L_last"},   ifa.L_last,   k == FL - 1);
    chk({t, " A.in_ready"}, ifa.in_ready, 1'b0);
    chk({t, " A.busy"},     ifa.busy,     1'b1);
    chk({t, " B.L_out"},    ifb.L_out,    model_bit(w, 1'b0, k));
    chk({t, " B.L_valid"},  ifb.L_valid,  1'b1);
    chk({t, " B.L_first"},  ifb.L_first,  k == 0);
    chk({t, " B.L_last"},   ifb.L_last,   k == FL - 1);
    chk({t, " B.in_ready"}, ifb.in_ready, 1'b0);
    chk({t, " B.busy"},     ifb.busy,     1'b1);
  endtask

  // mode 0: always ready; 1: random ready; 2: three-cycle stall on bit index 3.
  // abort_at >= 0 pulls rst_n low mid-cycle while that bit is presented.
  task automatic send_word(input logic [N-1:0] w, input int mode, input bit hold,
                           input int abort_at);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    @(negedge clk);
    check_idle($sformatf("pre w=%02h", w));
    in_data  = w;
    in_valid = 1'b1;
    L_ready  = 1'($urandom);
    while (k < FL) begin
      @(negedge clk);
      in_valid = hold;
      in_data  = N'($urandom);
      check_bit(w, k);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle("async reset");
        return;
      end
      case (mode)
        0:       L_ready = 1'b1;
        1:       L_ready = ($urandom_range(0, 3) != 0);
        default: begin
          L_ready = !(k == 3 && stalls < 3);
          if (!L_ready) stalls++;
        end
      endcase
      if (L_ready) k++;
      cyc++;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL frame timeout w=%02h: bits sent=%0d required=%0d", w, k, FL);
        return;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = N'($urandom);
    L_ready  = 1'b0;
    #3 check_idle("reset");
    #20;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    send_word(8'hA5, 0, 1'b0, -1);
    send_word(8'h01, 0, 1'b0, -1);
    send_word(8'hA5, 2, 1'b0, -1);
    send_word(8'h07, 0, 1'b0, -1);

    send_word(8'hFF, 0, 1'b0, 4);
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      in_data = N'($urandom);
      check_idle("held reset");
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    send_word(8'h0F, 0, 1'b0, -1);

    send_word(8'h81, 0, 1'b1, -1);
    send_word(8'h7E, 0, 1'b1, -1);

    for (int i = 0; i < 24; i++) begin
      send_word(N'($urandom), ($urandom_range(0, 2) == 0) ? 0 : 1,
                1'($urandom), -1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    check_idle("end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
